// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package nibble_serial_sub_pkg;

    localparam int unsigned NibbleW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Number of nibble steps needed for a WIDTH-bit operand.
    function automatic int unsigned num_nibbles(input int unsigned width);
        return width / NibbleW;
    endfunction

    // Width of the nibble index counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(num_nibbles(width));
    endfunction

endpackage

// File: rtl/sub4_borrow_lookahead.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bin.
module sub4_borrow_lookahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and the flattened borrow lookahead.
    always_comb begin
        g    = ~a & b;
        p    = ~(a ^ b);
        c[0] = bin;
        c[1] = g[0] | (p[0] & bin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & bin);
        d    = a ^ b ^ c[3:0];
        bout = c[4];
    end

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: diff = a - b - b_in, one nibble per clock, LSB first.
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int unsigned N  = num_nibbles(WIDTH);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] KLast = CW'(N - 1);

    state_e state_q, state_d;

    // Operands shift right one nibble per step, so the active nibble is always [3:0].
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             borrow_q;
    logic [CW-1:0]    k_q;
    logic             b_out_q, ovf_q;

    logic             accept, last;
    logic [3:0]       slice_d;
    logic             slice_bout;

    assign accept = in_valid && (state_q == StIdle);
    assign last   = (state_q == StRun) && (k_q == KLast);

    sub4_borrow_lookahead u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (k_q == KLast) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch operands on accept, then one slice step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= b_in;
            k_q      <= '0;
        end else if (state_q == StRun) begin
            a_q      <= a_q >> NibbleW;
            b_q      <= b_q >> NibbleW;
            borrow_q <= slice_bout;
            k_q      <= k_q + CW'(1);
            // Nibbles enter from the top; after N steps nibble 0 sits at the bottom.
            diff_q   <= {slice_d, diff_q[WIDTH-1:NibbleW]};
            if (last) begin
                b_out_q <= slice_bout;
                // On the last step a_q[3]/b_q[3] are the operand MSBs.
                ovf_q   <= (a_q[3] ^ b_q[3]) & (slice_d[3] ^ a_q[3]);
            end
        end
    end

    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed and random checks for nibble_serial_sub at WIDTH=16.
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_sub #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle, then scramble the inputs.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        b_in     = tbin;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        b_in     = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_reached", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic take_result(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tbin, input logic [15:0] ed, input logic eb,
                            input logic eo);
        int cyc;
        start_op(ta, tb, tbin);
        wait_done(cyc);
        check({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        check({tag, "_b_out"}, {31'd0, b_out}, {31'd0, eb});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        take_result(0);
    endtask

    initial begin
        int          cyc;
        logic [15:0] hd;
        logic        hb, ho;
        logic [16:0] ref_full;
        logic [15:0] ra, rb;
        logic        rbin, rovf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_diff", {16'd0, diff}, 32'd0);
        check("reset_b_out", {31'd0, b_out}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic case plus latency: out_valid after exactly 4 edges past accept.
        start_op(16'h1234, 16'h0234, 1'b0);
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done(cyc);
        check("latency", cyc, 32'd4);
        check("basic_diff", {16'd0, diff}, 32'h1000);
        check("basic_b_out", {31'd0, b_out}, 32'd0);
        check("basic_ovf", {31'd0, ovf}, 32'd0);
        take_result(0);

        directed("zero_minus_one", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        directed("min_minus_one", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        directed("bin_wrap", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
        directed("max_minus_neg1", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Backpressure: hold in DONE, wiggle inputs, outputs must not move.
        start_op(16'h5A5A, 16'h1111, 1'b1);
        wait_done(cyc);
        hd = diff;
        hb = b_out;
        ho = ovf;
        check("bp_diff", {16'd0, hd}, 32'h4948);
        check("bp_b_out", {31'd0, hb}, 32'd0);
        check("bp_ovf", {31'd0, ho}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'($urandom);
            b        = 16'($urandom);
            b_in     = ~b_in;
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_diff", {16'd0, diff}, {16'd0, 16'h4948});
            check("bp_hold_b_out", {31'd0, b_out}, 32'd0);
            check("bp_hold_ovf", {31'd0, ovf}, 32'd0);
        end
        in_valid = 1'b0;
        take_result(0);
        @(negedge clk);
        check("bp_no_second_accept", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of RUN at k=2.
        start_op(16'h1111, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_diff", {16'd0, diff}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        directed("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0);

        // Random operands against a WIDTH+1 bit reference.
        for (int n = 0; n < 1000; n++) begin
            ra       = 16'($urandom);
            rb       = 16'($urandom);
            rbin     = 1'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            rovf     = (ra[15] != rb[15]) && (ref_full[15] != ra[15]);
            start_op(ra, rb, rbin);
            wait_done(cyc);
            check("rand_diff", {16'd0, diff}, {16'd0, ref_full[15:0]});
            check("rand_b_out", {31'd0, b_out}, {31'd0, ref_full[16]});
            check("rand_ovf", {31'd0, ovf}, {31'd0, rovf});
            take_result(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
